uart_tx_piso: RTL

// - Transmit half of the full-duplex UART core: parallel-in/serial-out framer and shifter.
// - Accepts one 8-bit byte per handshake and builds an 11-bit frame:

---
 rtl/uart_tx_piso_pkg.sv | 35 +++
 rtl/uart_tx_piso_if.sv | 28 ++
 rtl/uart_tx_piso_parity_gen.sv | 14 +
 rtl/uart_tx_piso.sv | 134 +++++++++++++
 4 files changed

// File: rtl/uart_tx_piso_pkg.sv
// Shared UART definitions: frame geometry, fixed frame bits, FSM encodings
// and the parity/frame helper functions used by transmitter and receiver.
`timescale 1ns/1ps
package uart_tx_piso_pkg;

   localparam int FRAME_W = 11;
   localparam int DATA_W  = 8;

   localparam logic START_BIT = 1'b0;
   localparam logic STOP_BIT  = 1'b1;

   // Transmit FSM encodings
   localparam logic [1:0] ST_IDLE = 2'b00;
   localparam logic [1:0] ST_SEND = 2'b01;
   localparam logic [1:0] ST_DONE = 2'b10;

   // Index of the stop bit, i.e. the last bit shifted out
   localparam logic [3:0] LAST_BIT = 4'd10;

   // Frame register value while nothing is loaded (all marking)
   localparam logic [FRAME_W-1:0] FRAME_IDLE = 11'h7FF;

   // Parity over the data bits; odd=1 flips even parity into odd parity
   function automatic logic calc_parity(input logic [DATA_W-1:0] data,
                                        input logic              odd);
      return (^data) ^ odd;
   endfunction

   // Frame layout, LSB shifted first: {stop, parity, D7..D0, start}
   function automatic logic [FRAME_W-1:0] build_frame(input logic [DATA_W-1:0] data,
                                                      input logic              par);
      return {STOP_BIT, par, data, START_BIT};
   endfunction

endpackage

// File: rtl/uart_tx_piso_if.sv
// Byte handshake between a frame producer and the UART transmitter.
`timescale 1ns/1ps
interface uart_tx_piso_if;
   import uart_tx_piso_pkg::*;

   logic [DATA_W-1:0] data_in;
   logic              tx_start;
   logic              tx;
   logic              busy;
   logic              tx_done;

   modport master (
      output data_in,
      output tx_start,
      input  tx,
      input  busy,
      input  tx_done
   );

   modport slave (
      input  data_in,
      input  tx_start,
      output tx,
      output busy,
      output tx_done
   );

endinterface

// File: rtl/uart_tx_piso_parity_gen.sv
// uart_parity_gen: parity bit for one data byte. Also used by the receive
// deframer so both directions agree on the parity definition.
`timescale 1ns/1ps
module uart_parity_gen
   import uart_tx_piso_pkg::*;
(
   input  logic [DATA_W-1:0] data,
   input  logic              odd,
   output logic              parity
);

   assign parity = calc_parity(data, odd);

endmodule

// File: rtl/uart_tx_piso.sv
// UART transmitter: frames one byte as start/D0..D7/parity/stop and shifts it
// out LSB first, holding each bit for OVERSAMPLE baud_clk cycles.
// tx, busy and tx_done all come straight from flops.
`timescale 1ns/1ps
module uart_tx_piso
   import uart_tx_piso_pkg::*;
#(
   parameter int OVERSAMPLE = 16,
   parameter bit PARITY_EN  = 1'b1,
   parameter bit PARITY_ODD = 1'b0
) (
   input  logic           baud_clk,
   input  logic           rstn,
   uart_tx_piso_if.slave  txif
);

   localparam int             OS_W    = $clog2(OVERSAMPLE);
   localparam logic [OS_W-1:0] OS_LAST = OS_W'(OVERSAMPLE - 1);

   logic [1:0]         state_q,   state_d;
   logic [OS_W-1:0]    os_cnt_q,  os_cnt_d;
   logic [3:0]         bit_cnt_q, bit_cnt_d;
   logic [FRAME_W-1:0] frame_q,   frame_d;
   logic               tx_q,      tx_d;
   logic               busy_q,    busy_d;
   logic               done_q,    done_d;

   logic               par_raw_s;
   logic               par_s;

   uart_parity_gen u_parity (
      .data   (txif.data_in),
      .odd    (PARITY_ODD),
      .parity (par_raw_s)
   );

   // Parity slot carries a second stop bit when parity is disabled
   always_comb begin
      par_s = 1'b1;
      if (PARITY_EN) begin
         par_s = par_raw_s;
      end else begin
         par_s = 1'b1;
      end
   end

   // FSM, frame latch and bit/oversample counters
   always_comb begin
      state_d   = state_q;
      os_cnt_d  = os_cnt_q;
      bit_cnt_d = bit_cnt_q;
      frame_d   = frame_q;
      case (state_q)
         ST_IDLE: begin
            if (txif.tx_start) begin
               frame_d   = build_frame(txif.data_in, par_s);
               bit_cnt_d = 4'd0;
               os_cnt_d  = '0;
               state_d   = ST_SEND;
            end else begin
               state_d   = ST_IDLE;
            end
         end
         ST_SEND: begin
            if (os_cnt_q == OS_LAST) begin
               os_cnt_d = '0;
               if (bit_cnt_q == LAST_BIT) begin
                  bit_cnt_d = 4'd0;
                  state_d   = ST_DONE;
               end else begin
                  bit_cnt_d = bit_cnt_q + 4'd1;
               end
            end else begin
               os_cnt_d = os_cnt_q + OS_W'(1);
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d   = ST_IDLE;
            os_cnt_d  = '0;
            bit_cnt_d = 4'd0;
            frame_d   = FRAME_IDLE;
         end
      endcase
   end

   // Outputs computed from the next state so the registered tx shows the
   // start bit on the cycle right after acceptance
   always_comb begin
      tx_d   = 1'b1;
      busy_d = 1'b0;
      done_d = 1'b0;
      if (state_d == ST_SEND) begin
         tx_d   = frame_d[bit_cnt_d];
         busy_d = 1'b1;
      end else begin
         tx_d   = 1'b1;
         busy_d = 1'b0;
      end
      if (state_d == ST_DONE) begin
         done_d = 1'b1;
      end else begin
         done_d = 1'b0;
      end
   end

   // State and output registers with synchronous active-low reset
   always_ff @(posedge baud_clk) begin
      if (!rstn) begin
         state_q   <= ST_IDLE;
         os_cnt_q  <= '0;
         bit_cnt_q <= 4'd0;
         frame_q   <= FRAME_IDLE;
         tx_q      <= 1'b1;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         os_cnt_q  <= os_cnt_d;
         bit_cnt_q <= bit_cnt_d;
         frame_q   <= frame_d;
         tx_q      <= tx_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
      end
   end

   assign txif.tx      = tx_q;
   assign txif.busy    = busy_q;
   assign txif.tx_done = done_q;

endmodule
